// File: rtl/scandoubler_pkg.sv
// ----------------------------------------------------------------------------
// scandoubler_pkg
// Shared definitions for the scandoubler framebuffer capture path.
//   BURST_WORDS  : pixel words per SDRAM burst
//   burst_tag_t  : x/y/frame tag carried with every queued burst
//   burst_t      : tag plus the eight words of one burst
//   BURST_BITS   : flat width of burst_t, used for storage ports
//   frame_wrap() : advances a framebuffer index modulo the buffer count
// ----------------------------------------------------------------------------
package scandoubler_pkg;

    localparam int BURST_WORDS = 8;

    typedef struct packed {
        logic [10:0] x_base;
        logic [10:0] y;
        logic [1:0]  frame;
    } burst_tag_t;

    typedef struct packed {
        burst_tag_t                   tag;
        logic [BURST_WORDS-1:0][15:0] words;
    } burst_t;

    localparam int BURST_BITS = $bits(burst_t);

    // Next framebuffer index, wrapping back to 0 after the last buffer.
    function automatic logic [1:0] frame_wrap(input logic [1:0] f, input int frames);
        logic [1:0] last;
        last = 2'(frames - 1);
        return (f == last) ? 2'd0 : f + 2'd1;
    endfunction

endpackage

// File: rtl/scandoubler_burst_fifo.sv
// ----------------------------------------------------------------------------
// scandoubler_burst_fifo
// Queue of complete bursts (tag + 8 words) held in an inferred RAM with a
// registered read port. The head entry is always presented on head_o.
//   clk_i        : clock
//   init_n_i     : synchronous active-low reset (empties the queue)
//   push_i       : commit push_data_i; ignored while full
//   push_data_i  : burst to enqueue
//   pop_i        : retire the head entry
//   full_o       : BURSTS entries queued
//   nonempty_o   : registered "queue holds at least one burst"
//   head_o       : registered copy of the head entry
// ----------------------------------------------------------------------------
module scandoubler_burst_fifo
    import scandoubler_pkg::*;
#(
    parameter int BURSTS = 4
) (
    input  logic                  clk_i,
    input  logic                  init_n_i,
    input  logic                  push_i,
    input  logic [BURST_BITS-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  nonempty_o,
    output logic [BURST_BITS-1:0] head_o
);

    localparam int PW = $clog2(BURSTS);
    localparam int CW = PW + 1;

    logic [BURST_BITS-1:0] mem [BURSTS];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  nonempty_q;
    logic [BURST_BITS-1:0] head_q;
    logic                  do_push, do_pop;

    assign full_o     = (count_q == CW'(BURSTS));
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && (count_q != '0);
    assign nonempty_o = nonempty_q;
    assign head_o     = head_q;

    // Pointer and occupancy next-state. Pointers wrap naturally because the
    // depth is a power of two; a simultaneous push and pop leaves the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Burst storage write port, kept free of reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Registered read of the next head. The bypass covers a push landing in
    // the slot that is about to become (or already is) the head, which
    // happens when the queue is empty or holds one entry that is popping.
    always_ff @(posedge clk_i) begin
        if (!init_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            nonempty_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            nonempty_q <= (count_d != '0);
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                head_q <= push_data_i;
            end else begin
                head_q <= mem[rd_ptr_d];
            end
        end
    end

endmodule

// File: rtl/scandoubler_vidin_writer.sv
// ----------------------------------------------------------------------------
// scandoubler_vidin_writer
// Packs a 16-bit pixel-word stream into 8-word bursts tagged with x/y/frame,
// queues them, and feeds them to the SDRAM controller's framebuffer write
// port through the vidin_req / vidin_ack handshake.
//   clk_96        : SDRAM clock, sole clock
//   init_n        : synchronous active-low reset
//   pix_ce/pix_d  : pixel word strobe and data
//   pix_hs/pix_vs : sync levels; rising edges start a new line / frame
//   vidin_req     : a burst is pending
//   vidin_frame/y : tags of the head burst
//   vidin_x/d     : word position and data, updated one cycle after each ack
//   vidin_ack     : controller advance strobe, 8 cycles per burst
//   frame_done    : last fully captured framebuffer
//   overflow      : sticky word-drop flag, cleared by clr_overflow
// ----------------------------------------------------------------------------
module scandoubler_vidin_writer
    import scandoubler_pkg::*;
#(
    parameter int BURSTS = 4,
    parameter int FRAMES = 2
) (
    input  logic        clk_96,
    input  logic        init_n,
    input  logic        pix_ce,
    input  logic [15:0] pix_d,
    input  logic        pix_hs,
    input  logic        pix_vs,
    output logic        vidin_req,
    output logic [1:0]  vidin_frame,
    output logic [10:0] vidin_x,
    output logic [10:0] vidin_y,
    output logic [15:0] vidin_d,
    input  logic        vidin_ack,
    output logic [1:0]  frame_done,
    output logic        overflow,
    input  logic        clr_overflow
);

    logic                         hs_q, vs_q, hs_rise, vs_rise;
    logic [10:0]                  wx_q, wx_d, wy_q, wy_d;
    logic [1:0]                   wf_q, wf_d;
    logic [BURST_WORDS-1:0][15:0] fill_q, fill_d;
    logic [1:0]                   frame_done_q, frame_done_d;
    logic                         overflow_q, overflow_d;
    logic [2:0]                   rp_q, rp_d;
    logic                         pop_pend_q, pop_pend_d;
    logic [10:0]                  vidin_x_q, vidin_x_d;
    logic [15:0]                  vidin_d_q, vidin_d_d;
    logic                         push, fifo_full, fifo_nonempty, ack_ok;
    burst_t                       push_burst, head;
    logic [BURST_BITS-1:0]        head_bits;

    scandoubler_burst_fifo #(.BURSTS(BURSTS)) u_fifo (
        .clk_i       (clk_96),
        .init_n_i    (init_n),
        .push_i      (push),
        .push_data_i (push_burst),
        .pop_i       (pop_pend_q),
        .full_o      (fifo_full),
        .nonempty_o  (fifo_nonempty),
        .head_o      (head_bits)
    );

    assign head        = head_bits;
    assign vidin_req   = fifo_nonempty;
    assign vidin_frame = head.tag.frame;
    assign vidin_y     = head.tag.y;
    assign vidin_x     = vidin_x_q;
    assign vidin_d     = vidin_d_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;

    // Input packer. Sync edges are handled before the word of the same
    // cycle, so that word opens the new line/frame; vs overrides hs. A burst
    // is flushed on an edge only if partly filled. Words arriving while the
    // queue is full are dropped but still advance wx to keep geometry.
    always_comb begin
        hs_rise      = pix_hs & ~hs_q;
        vs_rise      = pix_vs & ~vs_q;
        wx_d         = wx_q;
        wy_d         = wy_q;
        wf_d         = wf_q;
        fill_d       = fill_q;
        frame_done_d = frame_done_q;
        overflow_d   = clr_overflow ? 1'b0 : overflow_q;
        push         = 1'b0;
        push_burst   = '0;

        if (hs_rise || vs_rise) begin
            if (wx_q[2:0] != 3'd0) begin
                push                    = 1'b1;
                push_burst.tag.x_base   = wx_q & ~11'd7;
                push_burst.tag.y        = wy_q;
                push_burst.tag.frame    = wf_q;
                push_burst.words        = fill_q;
            end
            wx_d = '0;
            if (vs_rise) begin
                wy_d         = '0;
                frame_done_d = wf_q;
                wf_d         = frame_wrap(wf_q, FRAMES);
            end else if (wy_q != 11'h7FF) begin
                wy_d = wy_q + 11'd1;
            end
        end

        if (pix_ce) begin
            if (fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                fill_d[wx_d[2:0]] = pix_d;
            end
            if (wx_d[2:0] == 3'd7) begin
                push                  = 1'b1;
                push_burst.tag.x_base = wx_d & ~11'd7;
                push_burst.tag.y      = wy_d;
                push_burst.tag.frame  = wf_d;
                push_burst.words      = fill_d;
            end
            wx_d = wx_d + 11'd1;
        end
    end

    // Output sequencer. Each accepted ack presents word rp of the head; the
    // 8th ack arms a pop that happens one cycle later so the controller can
    // still sample the last word against the old head tags. Acks during that
    // extra cycle are ignored.
    always_comb begin
        ack_ok     = vidin_ack && vidin_req && !pop_pend_q;
        rp_d       = rp_q;
        pop_pend_d = 1'b0;
        vidin_x_d  = vidin_x_q;
        vidin_d_d  = vidin_d_q;
        if (ack_ok) begin
            vidin_d_d  = head.words[rp_q];
            vidin_x_d  = head.tag.x_base + 11'(rp_q);
            rp_d       = rp_q + 3'd1;
            pop_pend_d = (rp_q == 3'd7);
        end
    end

    // State registers. Sync history loads the live levels in reset so a
    // sync held high across reset release is not seen as an edge.
    always_ff @(posedge clk_96) begin
        if (!init_n) begin
            hs_q         <= pix_hs;
            vs_q         <= pix_vs;
            wx_q         <= '0;
            wy_q         <= '0;
            wf_q         <= '0;
            fill_q       <= '0;
            frame_done_q <= 2'(FRAMES - 1);
            overflow_q   <= 1'b0;
            rp_q         <= '0;
            pop_pend_q   <= 1'b0;
            vidin_x_q    <= '0;
            vidin_d_q    <= '0;
        end else begin
            hs_q         <= pix_hs;
            vs_q         <= pix_vs;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            wf_q         <= wf_d;
            fill_q       <= fill_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            rp_q         <= rp_d;
            pop_pend_q   <= pop_pend_d;
            vidin_x_q    <= vidin_x_d;
            vidin_d_q    <= vidin_d_d;
        end
    end

endmodule

// File: tb/tb_scandoubler_vidin_writer.sv
// ----------------------------------------------------------------------------
// tb_scandoubler_vidin_writer
// Directed bench for scandoubler_vidin_writer (BURSTS=4, FRAMES=3) with a
// small controller model that acks 8 cycles per burst.
// ----------------------------------------------------------------------------
module tb_scandoubler_vidin_writer;

    logic        clk_96 = 1'b0;
    logic        init_n;
    logic        pix_ce;
    logic [15:0] pix_d;
    logic        pix_hs;
    logic        pix_vs;
    logic        vidin_req;
    logic [1:0]  vidin_frame;
    logic [10:0] vidin_x;
    logic [10:0] vidin_y;
    logic [15:0] vidin_d;
    logic        vidin_ack;
    logic [1:0]  frame_done;
    logic        overflow;
    logic        clr_overflow;

    int checkCount = 0;
    int errorCount = 0;

    // 10 ns clock
    always #5 clk_96 = ~clk_96;

    scandoubler_vidin_writer #(.BURSTS(4), .FRAMES(3)) dut (
        .clk_96       (clk_96),
        .init_n       (init_n),
        .pix_ce       (pix_ce),
        .pix_d        (pix_d),
        .pix_hs       (pix_hs),
        .pix_vs       (pix_vs),
        .vidin_req    (vidin_req),
        .vidin_frame  (vidin_frame),
        .vidin_x      (vidin_x),
        .vidin_y      (vidin_y),
        .vidin_d      (vidin_d),
        .vidin_ack    (vidin_ack),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_96);
        #1;
    endtask

    // Hold one cycle of pixel-side inputs across a clock edge.
    task automatic applyStimulus(input logic ce, input logic [15:0] d,
                                 input logic hs, input logic vs);
        pix_ce = ce;
        pix_d  = d;
        pix_hs = hs;
        pix_vs = vs;
        tick();
        pix_ce = 1'b0;
    endtask

    task automatic pulseHs();
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic pulseVs();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic sendWords(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, base + 16'(i), 1'b0, 1'b0);
        end
    endtask

    // Controller model: wait for a request, check head tags, ack 8 cycles,
    // check each presented word, then let the retire cycle pass.
    task automatic drainBurst(input string tag, input int y, input int frame,
                              input int xBase, input int dBase, input int nCheck);
        int waitCycles;
        waitCycles = 0;
        while (!vidin_req && waitCycles < 32) begin
            tick();
            waitCycles++;
        end
        if (!vidin_req) begin
            checkOutput({tag, "_reqTimeout"}, 32'(vidin_req), 32'd1);
            return;
        end
        checkOutput({tag, "_y"}, 32'(vidin_y), 32'(y));
        checkOutput({tag, "_frame"}, 32'(vidin_frame), 32'(frame));
        vidin_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 7) vidin_ack = 1'b0;
            checkOutput({tag, "_x"}, 32'(vidin_x), 32'(xBase + k));
            if (k < nCheck) checkOutput({tag, "_d"}, 32'(vidin_d), 32'(dBase + k));
        end
        checkOutput({tag, "_yHold"}, 32'(vidin_y), 32'(y));
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expDone [4];
        expDone = '{0, 1, 2, 0};

        init_n       = 1'b0;
        pix_ce       = 1'b0;
        pix_d        = '0;
        pix_hs       = 1'b0;
        pix_vs       = 1'b0;
        vidin_ack    = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_req", 32'(vidin_req), 32'd0);
        checkOutput("rst_x", 32'(vidin_x), 32'd0);
        checkOutput("rst_y", 32'(vidin_y), 32'd0);
        checkOutput("rst_frame", 32'(vidin_frame), 32'd0);
        checkOutput("rst_d", 32'(vidin_d), 32'd0);
        checkOutput("rst_frameDone", 32'(frame_done), 32'd2);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        init_n = 1'b1;
        tick();

        $display("[TB] two bursts on row 5");
        repeat (5) pulseHs();
        sendWords(16'h0000, 16);
        drainBurst("t1b0", 5, 0, 0, 0, 8);
        drainBurst("t1b1", 5, 0, 8, 8, 8);
        checkOutput("t1_reqLow", 32'(vidin_req), 32'd0);

        $display("[TB] partial burst flushed by hs");
        pulseHs();
        sendWords(16'h00A0, 3);
        pulseHs();
        sendWords(16'h00B0, 8);
        drainBurst("t2p", 6, 0, 0, 'hA0, 3);
        drainBurst("t2n", 7, 0, 0, 'hB0, 8);

        $display("[TB] frame cycling");
        for (int i = 0; i < 4; i++) begin
            sendWords(16'(32'hC0 + 8 * i), 8);
            pulseVs();
            checkOutput("t3_frameDone", 32'(frame_done), 32'(expDone[i]));
        end
        drainBurst("t3f0", 7, 0, 8, 'hC0, 8);
        drainBurst("t3f1", 0, 1, 0, 'hC8, 8);
        drainBurst("t3f2", 0, 2, 0, 'hD0, 8);
        drainBurst("t3f3", 0, 0, 0, 'hD8, 8);
        checkOutput("t3_noOverflow", 32'(overflow), 32'd0);

        $display("[TB] overflow with ack held low");
        sendWords(16'h0100, 40);
        checkOutput("t4_overflowSet", 32'(overflow), 32'd1);
        checkOutput("t4_reqHigh", 32'(vidin_req), 32'd1);
        for (int b = 0; b < 4; b++) begin
            drainBurst("t4b", 0, 1, 8 * b, 'h100 + 8 * b, 8);
        end
        checkOutput("t4_fifthLost", 32'(vidin_req), 32'd0);
        sendWords(16'h0200, 8);
        drainBurst("t4c", 0, 1, 40, 'h200, 8);
        checkOutput("t4_overflowSticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checkOutput("t4_overflowClr", 32'(overflow), 32'd0);

        $display("[TB] commit and retire together");
        sendWords(16'h0300, 16);
        checkOutput("t5_reqPre", 32'(vidin_req), 32'd1);
        for (int c = 0; c <= 8; c++) begin
            vidin_ack = (c < 8);
            pix_ce    = (c >= 1);
            pix_d     = 16'h03FF + 16'(c);
            tick();
            if (c < 8) begin
                checkOutput("t5_x", 32'(vidin_x), 32'(48 + c));
                checkOutput("t5_d", 32'(vidin_d), 32'(32'h300 + c));
            end
        end
        pix_ce    = 1'b0;
        vidin_ack = 1'b0;
        checkOutput("t5_reqHold", 32'(vidin_req), 32'd1);
        drainBurst("t5b1", 0, 1, 56, 'h308, 8);
        drainBurst("t5b2", 0, 1, 64, 'h400, 8);
        checkOutput("t5_reqLow", 32'(vidin_req), 32'd0);

        $display("[TB] reset mid-burst");
        sendWords(16'h0500, 8);
        checkOutput("t6_reqPre", 32'(vidin_req), 32'd1);
        vidin_ack = 1'b1;
        tick();
        tick();
        tick();
        init_n = 1'b0;
        pix_vs = 1'b1;
        tick();
        vidin_ack = 1'b0;
        init_n    = 1'b1;
        checkOutput("t6_reqLow", 32'(vidin_req), 32'd0);
        checkOutput("t6_x", 32'(vidin_x), 32'd0);
        checkOutput("t6_d", 32'(vidin_d), 32'd0);
        checkOutput("t6_frameDoneRst", 32'(frame_done), 32'd2);
        repeat (3) tick();
        checkOutput("t6_frameDoneHold", 32'(frame_done), 32'd2);
        checkOutput("t6_queueEmpty", 32'(vidin_req), 32'd0);
        pix_vs = 1'b0;
        tick();
        sendWords(16'h0600, 8);
        drainBurst("t6", 0, 0, 0, 'h600, 8);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/scandoubler_vidin_writer.md
# scandoubler_vidin_writer

Capture-side client of the scandoubler SDRAM controller's framebuffer write port. Takes a 16-bit pixel-word stream with sync pulses, packs it into 8-word bursts, and queues the bursts with their x/y/frame tags. It drives the controller's `vidin_req` / `vidin_ack` handshake so each queued burst is written into the double/triple-buffered framebuffer bank. It sits between the core's video output and the SDRAM controller, and is the producer that the scandoubler read side consumes.

## Interface
Parameters:
- `BURSTS`, default 4: queue depth in 8-word bursts; must be a power of 2, range 2..8.
- `FRAMES`, default 2: number of framebuffers cycled through, range 2..4.

Ports:
- `clk_96` in 1: sole clock, the SDRAM clock domain.
- `init_n` in 1: reset, synchronous, active-low.
- `pix_ce` in 1: `pix_d` is valid this cycle.
- `pix_d` in 16: pixel word.
- `pix_hs` in 1: horizontal sync, active-high level. Its rising edge starts a new line.
- `pix_vs` in 1: vertical sync, active-high level. Its rising edge starts a new frame.
- `vidin_req` out 1: a burst is pending.
- `vidin_frame` out 2: frame tag of the head burst.
- `vidin_x` out 11: word x position of the current word.
- `vidin_y` out 11: line of the head burst.
- `vidin_d` out 16: current word.
- `vidin_ack` in 1: controller's advance strobe; high for 8 consecutive cycles per burst.
- `frame_done` out 2: index of the last fully captured frame.
- `overflow` out 1: sticky; set when a word is dropped.
- `clr_overflow` in 1: clears `overflow`.

## Operation
Input side:
- Rising edges of `pix_hs` and `pix_vs` are detected against one registered copy of each. Edge detection is independent of `pix_ce`.
- Write cursor: `wx` (11 bits), `wy` (11 bits), `wf` (2 bits).
  - Each accepted word goes into slot `wx[2:0]` of the fill burst, then `wx` increments.
  - When `wx[2:0]` wraps 7→0, the fill burst is committed to the queue with tags `{x_base = wx & ~7, wy, wf}`.
- hs edge:
  - If the fill burst is partial, commit it. Unwritten slots hold stale data and are written anyway.
  - Then `wx ← 0` and `wy ← wy + 1`, saturating at 2047.
- vs edge:
  - Flush the partial burst as for hs.
  - `frame_done ← wf`.
  - `wf ← (wf == FRAMES-1) ? 0 : wf + 1`.
  - `wx ← 0`, `wy ← 0`.
- Simultaneous edge and `pix_ce` in the same cycle: the edge is processed first and the word belongs to the new line/frame. If hs and vs coincide, vs wins.
- Queue full (`BURSTS` committed) and a word arrives:
  - The word is dropped and `overflow ← 1`.
  - `wx` still increments, so geometry is preserved.
  - A commit attempted while full is discarded.
- `clr_overflow` clears the flag. If a drop occurs in the same cycle, set wins.

Output side:
- `vidin_req = queue non-empty`, registered.
- `vidin_frame` and `vidin_y` come from the head entry.
- Word read pointer `rp` (3 bits) resets to 0 per burst.
- On each cycle with `vidin_ack && vidin_req`:
  - `vidin_d ← word[rp]`
  - `vidin_x ← x_base + rp`
  - `rp ← rp + 1`
  - The controller samples the pair one cycle after each ack, so the k-th ack presents word k-1.
- Retire: after the 8th ack the head stays valid for exactly one further cycle, then pops.
  - `vidin_req` is recomputed from the remaining entries.
  - `vidin_frame` and `vidin_y` switch to the new head.
- `vidin_ack` while `vidin_req` is low is ignored.

## Timing
- Reset (`init_n` low at a clock edge):
  - `vidin_req=0`, `vidin_x=0`, `vidin_y=0`, `vidin_frame=0`, `vidin_d=0`.
  - `frame_done=FRAMES-1`, `overflow=0`.
  - Queue empty, cursors 0, `rp=0`.
  - Sync-edge history ← current levels, so no false edge is seen after reset.
  - Reset mid-burst abandons the burst silently.
- Commit to `vidin_req` high: 1 cycle, when the queue was empty.
- 8th ack to pop: 2 cycles. `vidin_req` falls on the second cycle if the queue is then empty.
- Pixel throughput: up to 1 word/clock at input. Sustained rate must stay below 8 words per controller slot.
- Queue occupancy counter is `$clog2(BURSTS)+1` bits. Simultaneous commit and pop leaves the count unchanged.

## Structure
- Shared package `scandoubler_pkg` holds:
  - `BURST_WORDS = 8`
  - the burst-tag struct `{x_base[10:0], y[10:0], frame[1:0]}`
  - the frame-wrap helper function.
- One sub-module, `scandoubler_burst_fifo`: tag-plus-8-word storage, `BURSTS` entries, in inferred RAM with registered read.
- Input packer and output sequencer live in the top.

## Test plan
- Reset, then 16 words `0x0000..0x000F` on row 5 (after 5 hs edges), then a controller model acking 8 cycles per burst. Expected:
  - two bursts with `vidin_y=5` and `vidin_x` 0..7 then 8..15;
  - the data pair delivered one cycle after each ack matches `x=d`.
- 3 words then hs. Expected: one burst at `x_base=0` with words 0..2 correct; next word lands at `wx=0`, `wy+1`.
- `FRAMES=3`, four vs edges. Expected: `wf` sequence 0,1,2,0; `frame_done` sequence 0,1,2,0; burst tags follow `wf`.
- Ack held low while 5×8 words stream with `BURSTS=4`. Expected:
  - `overflow=1`, 4 bursts queued, the 5th burst's words lost;
  - after draining, `vidin_x` continues at 40;
  - `clr_overflow` clears the flag.
- Commit and retire in the same cycle with queue at 2. Expected: count stays 2 and `vidin_req` stays high.
- `init_n` low during ack 4 of a burst. Expected: next cycle `vidin_req=0`; queue empty; no spurious `frame_done` change when `pix_vs` is high at release.
